// File: rtl/adder_accum_seq.sv
// Sequencer in front of a combinational WIDTH-bit adder: registers the adder
// operands, folds the adder outputs into a running sum with sticky flags.
module adder_accum_seq #(
   parameter int WIDTH   = 32,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COUNT_W-1:0] len,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic [WIDTH-1:0]   adder_a,
   output logic [WIDTH-1:0]   adder_b,
   input  logic [WIDTH-1:0]   adder_sum,
   input  logic               adder_carryout,
   input  logic               adder_overflow,
   output logic               busy,
   output logic               result_valid,
   input  logic               result_ready,
   output logic [WIDTH-1:0]   result,
   output logic               carry_sticky,
   output logic               overflow_sticky
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      ADD    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [COUNT_W-1:0] remaining;
   logic               job_go;
   logic               op_take;
   logic               add_commit;
   logic               last_add;

   assign last_add = (remaining == COUNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake outputs decode from state alone so in_ready never depends on in_valid.
   always_comb begin
      state_nxt    = state;
      in_ready     = 1'b0;
      busy         = 1'b1;
      result_valid = 1'b0;
      job_go       = 1'b0;
      op_take      = 1'b0;
      add_commit   = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               job_go    = 1'b1;
               state_nxt = (len == '0) ? DONE : ACCEPT;
            end
         end
         ACCEPT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               op_take   = 1'b1;
               state_nxt = ADD;
            end
         end
         ADD: begin
            add_commit = 1'b1;
            state_nxt  = last_add ? DONE : ACCEPT;
         end
         DONE: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The adder settles from the registered operands during ADD; its outputs land here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adder_a         <= '0;
         adder_b         <= '0;
         result          <= '0;
         remaining       <= '0;
         carry_sticky    <= 1'b0;
         overflow_sticky <= 1'b0;
      end else begin
         if (job_go) begin
            adder_a         <= '0;
            result          <= '0;
            remaining       <= len;
            carry_sticky    <= 1'b0;
            overflow_sticky <= 1'b0;
         end
         if (op_take) begin
            adder_b <= in_data;
         end
         if (add_commit) begin
            adder_a         <= adder_sum;
            result          <= adder_sum;
            remaining       <= remaining - COUNT_W'(1);
            carry_sticky    <= carry_sticky | adder_carryout;
            overflow_sticky <= overflow_sticky | adder_overflow;
         end
      end
   end

endmodule

// File: tb/tb_adder_accum_seq.sv
// Bench for adder_accum_seq: an ideal 32-bit adder sits behind adder_a/adder_b,
// and each job's sum and flags are predicted with plain wide arithmetic.
module tb_adder_accum_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] adder_a;
   logic [31:0] adder_b;
   logic [31:0] adder_sum;
   logic        adder_carryout;
   logic        adder_overflow;
   logic        busy;
   logic        result_valid;
   logic        result_ready;
   logic [31:0] result;
   logic        carry_sticky;
   logic        overflow_sticky;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] ops[$];

   adder_accum_seq #(.WIDTH(32), .COUNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
      .adder_carryout(adder_carryout), .adder_overflow(adder_overflow),
      .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
      .result(result), .carry_sticky(carry_sticky), .overflow_sticky(overflow_sticky)
   );

   // Stand-in for the downstream combinational adder.
   logic [32:0] add_full;
   assign add_full       = {1'b0, adder_a} + {1'b0, adder_b};
   assign adder_sum      = add_full[31:0];
   assign adder_carryout = add_full[32];
   assign adder_overflow = (adder_a[31] == adder_b[31]) && (adder_sum[31] != adder_a[31]);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference step: unsigned carry and signed overflow judged on 64-bit values.
   task automatic model_add(inout logic [31:0] acc, inout bit c, inout bit v, input logic [31:0] op);
      logic [63:0] u;
      longint      s;
      u = {32'b0, acc} + {32'b0, op};
      s = longint'($signed(acc)) + longint'($signed(op));
      if (u > 64'h0000_0000_FFFF_FFFF) c = 1'b1;
      if (s > 64'sd2147483647 || s < -64'sd2147483648) v = 1'b1;
      acc = u[31:0];
   endtask

   task automatic run_job(input int gap, input int rdly, input bit poke_start, input bit start_at_ack);
      int          n;
      int          c0;
      int          w;
      logic [31:0] rs;
      bit          rc;
      bit          rv;
      n  = ops.size();
      rs = '0;
      rc = 1'b0;
      rv = 1'b0;
      @(negedge clk);
      start = 1'b1;
      len   = 8'(n);
      c0    = cyc;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         w = 0;
         while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
         end
         if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            return;
         end
         for (int g = 0; g < gap; g++) begin
            if (poke_start && g == 0) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("gap_ready_busy", {in_ready, busy}, 2'b11);
         end
         in_valid = 1'b1;
         in_data  = ops[k];
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = $urandom;
         chk("adder_b", adder_b, ops[k]);
         chk("add_in_ready", in_ready, 1'b0);
         model_add(rs, rc, rv, ops[k]);
         @(negedge clk);
         chk("partial_sum", adder_a, rs);
         chk("partial_flags", {carry_sticky, overflow_sticky}, {rc, rv});
      end
      w = 0;
      while (!result_valid && w < 50) begin
         chk("no_ready_when_waiting", in_ready, 1'b0);
         @(negedge clk);
         w++;
      end
      if (!result_valid) begin
         chk("done_timeout", 0, 1);
         return;
      end
      if (gap == 0) chk("latency", cyc - c0, 2 * n + 1);
      chk("result", result, rs);
      chk("flags", {carry_sticky, overflow_sticky}, {rc, rv});
      chk("done_busy_ready", {busy, in_ready}, 2'b10);
      for (int r = 0; r < rdly; r++) begin
         @(negedge clk);
         chk("done_hold", {result_valid, busy, result, carry_sticky, overflow_sticky},
             {2'b11, rs, rc, rv});
      end
      result_ready = 1'b1;
      if (start_at_ack) begin
         start = 1'b1;
         len   = 8'd3;
      end
      @(negedge clk);
      result_ready = 1'b0;
      start        = 1'b0;
      chk("ack_to_idle", {result_valid, busy}, 2'b00);
      @(negedge clk);
      chk("idle_stays", {busy, in_ready}, 2'b00);
      chk("idle_holds", {result, carry_sticky, overflow_sticky}, {rs, rc, rv});
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      len          = '0;
      in_valid     = 1'b0;
      in_data      = '0;
      result_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_state", {adder_a, adder_b, result, carry_sticky, overflow_sticky,
                          in_ready, busy, result_valid}, '0);
      rst_n = 1'b1;

      ops = '{32'd1, 32'd2, 32'd3};
      run_job(0, 0, 1'b0, 1'b0);
      ops = '{32'hFFFF_FFFF, 32'h0000_0001};
      run_job(0, 0, 1'b0, 1'b0);
      ops = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
      run_job(0, 1, 1'b0, 1'b0);
      ops = {};
      run_job(0, 0, 1'b0, 1'b0);
      ops = '{$urandom, $urandom};
      run_job(3, 5, 1'b1, 1'b1);

      // Asynchronous reset landing between edges in the middle of a job.
      @(negedge clk);
      start = 1'b1;
      len   = 8'd3;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'd5;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_accept", {in_ready, adder_a}, {1'b1, 32'd5});
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", {adder_a, adder_b, result, carry_sticky, overflow_sticky,
                          in_ready, busy, result_valid}, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ops = '{32'h1234_5678};
      run_job(0, 0, 1'b0, 1'b0);

      for (int j = 0; j < 8; j++) begin
         ops = {};
         for (int k = 0; k < $urandom_range(1, 6); k++) begin
            case ($urandom_range(0, 3))
               0:       ops.push_back(32'h7FFF_FFFF - $urandom_range(0, 3));
               1:       ops.push_back(32'h8000_0000 + $urandom_range(0, 3));
               default: ops.push_back($urandom);
            endcase
         end
         run_job($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end

      ops = {};
      for (int k = 0; k < 255; k++) ops.push_back($urandom);
      run_job(0, 0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
